// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving data_path from the IR it loads.
// Optional macro SINGLE_STEP_EN adds a Step input that gates the T2->T3 transition.
module control_sequencer #(
  parameter logic [4:0] HALT_OPCODE = 5'b11010,
  parameter logic [4:0] MUL_OPCODE  = 5'b01111,
  parameter logic [4:0] DIV_OPCODE  = 5'b10000
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  op,
  output logic        PCout,
  output logic        MARin,
  output logic        InPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8
  } state_t;

  state_t      state_r;
  logic [4:0]  opcode_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic [3:0]  rc_s;
  logic        is_halt_s;
  logic        is_undef_s;
  logic        is_muldiv_s;
  logic        is_unary_s;
  logic        step_ok_s;
  logic        unused_ir_s;

  assign opcode_s    = IR[31:27];
  assign ra_s        = IR[26:23];
  assign rb_s        = IR[22:19];
  assign rc_s        = IR[18:15];
  assign unused_ir_s = ^IR[14:0];

  assign is_halt_s   = (opcode_s == HALT_OPCODE);
  assign is_undef_s  = (opcode_s > 5'b10010) && !is_halt_s;
  assign is_muldiv_s = (opcode_s == MUL_OPCODE) || (opcode_s == DIV_OPCODE);
  assign is_unary_s  = (opcode_s == 5'b10001) || (opcode_s == 5'b10010);

`ifdef SINGLE_STEP_EN
  assign step_ok_s = Step;
`else
  assign step_ok_s = 1'b1;
`endif

  // State advances on the falling edge so controls settle before the datapath rising edge.
  always_ff @(negedge Clock or posedge clear) begin
    if (clear) begin
      state_r <= S_RESET;
    end else begin
      case (state_r)
        S_RESET: state_r <= S_T0;
        S_T0:    state_r <= S_T1;
        S_T1:    state_r <= S_T2;
        S_T2:    state_r <= step_ok_s ? S_T3 : S_T2;
        S_T3: begin
          if (is_halt_s)       state_r <= S_HALT;
          else if (is_undef_s) state_r <= S_T0;
          else                 state_r <= S_T4;
        end
        S_T4:    state_r <= S_T5;
        S_T5:    state_r <= is_muldiv_s ? S_T6 : S_T0;
        S_T6:    state_r <= S_T0;
        S_HALT:  state_r <= S_HALT;
        default: state_r <= S_RESET;
      endcase
    end
  end

  // Control decode from the current state and the loaded instruction.
  always_comb begin
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    op       = 5'b00000;
    PCout    = 1'b0;
    MARin    = 1'b0;
    InPC     = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZHighin  = 1'b0;
    Zlowin   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Run      = 1'b0;
    case (state_r)
      S_T0: begin
        Run     = 1'b1;
        PCout   = 1'b1;
        MARin   = 1'b1;
        InPC    = 1'b1;
        ZHighin = 1'b1;
        Zlowin  = 1'b1;
        op      = 5'b00011;
      end
      S_T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        if (!is_halt_s && !is_undef_s) begin
          Rout = 16'h0001 << rb_s;
          Yin  = 1'b1;
        end else begin
          Yin  = 1'b0;
        end
      end
      S_T4: begin
        Run     = 1'b1;
        ZHighin = 1'b1;
        Zlowin  = 1'b1;
        op      = opcode_s;
        // Unary ops take their single operand from Rb; everything else reads Rc here.
        if (is_unary_s) begin
          Rout = 16'h0001 << rb_s;
        end else begin
          Rout = 16'h0001 << rc_s;
        end
      end
      S_T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (is_muldiv_s) begin
          LOin = 1'b1;
        end else begin
          Rin  = 16'h0001 << ra_s;
        end
      end
      S_T6: begin
        Run      = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_HALT:  Run = 1'b0;
      S_RESET: Run = 1'b0;
      default: Run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; samples one time unit after each posedge.
module tb_control_sequencer;

  logic        Clock;
  logic        clear;
  logic [31:0] IR;
  logic        Step;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  op;
  logic PCout, MARin, InPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, Run;
  logic [15:0] ctl;

  int n_cmp;
  int n_err;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .IR(IR),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .Rin(Rin), .Rout(Rout), .op(op),
    .PCout(PCout), .MARin(MARin), .InPC(InPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin),
    .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin),
    .LOin(LOin), .Run(Run)
  );

  // Bit order: PCout MARin InPC PCin Read MDRin MDRout IRin Yin ZHighin Zlowin Zhighout Zlowout HIin LOin Run
  assign ctl = {PCout, MARin, InPC, PCin, Read, MDRin, MDRout, IRin,
                Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_ctl,
                             input logic [15:0] e_rin, input logic [15:0] e_rout,
                             input logic [4:0] e_op);
    check_eq({tag, "_ctl"},  {16'h0000, ctl}, {16'h0000, e_ctl});
    check_eq({tag, "_rin"},  {16'h0000, Rin}, {16'h0000, e_rin});
    check_eq({tag, "_rout"}, {16'h0000, Rout}, {16'h0000, e_rout});
    check_eq({tag, "_op"},   {27'h0, op},     {27'h0, e_op});
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Checks T0..T2 starting at a T0 sample and leaves the bench at the T3 sample.
  task automatic fetch(input string tag);
    check_state({tag, "_t0"}, 16'hE061, 16'h0000, 16'h0000, 5'b00011);
    step();
    check_state({tag, "_t1"}, 16'h1C09, 16'h0000, 16'h0000, 5'b00000);
    step();
    check_state({tag, "_t2"}, 16'h0301, 16'h0000, 16'h0000, 5'b00000);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear = 1'b1;
    Step  = 1'b1;
    IR    = 32'h18918000;
    #2;
    check_state("reset", 16'h0000, 16'h0000, 16'h0000, 5'b00000);
    step();
    clear = 1'b0;
    step();

    // add R1,R2,R3
    fetch("add");
    check_state("add_t3", 16'h0081, 16'h0000, 16'h0004, 5'b00000);
    step();
    check_state("add_t4", 16'h0061, 16'h0000, 16'h0008, 5'b00011);
    step();
    check_state("add_t5", 16'h0009, 16'h0002, 16'h0000, 5'b00000);
    step();

    // mul R0,R4,R5: expects T0 again after 7 cycles
    IR = {5'b01111, 4'd0, 4'd4, 4'd5, 15'd0};
    fetch("mul");
    check_state("mul_t3", 16'h0081, 16'h0000, 16'h0010, 5'b00000);
    step();
    check_state("mul_t4", 16'h0061, 16'h0000, 16'h0020, 5'b01111);
    step();
    check_state("mul_t5", 16'h000B, 16'h0000, 16'h0000, 5'b00000);
    step();
    check_state("mul_t6", 16'h0015, 16'h0000, 16'h0000, 5'b00000);
    step();

    // not R7,R6
    IR = {5'b10010, 4'd7, 4'd6, 4'd0, 15'd0};
    fetch("not");
    check_state("not_t3", 16'h0081, 16'h0000, 16'h0040, 5'b00000);
    step();
    check_state("not_t4", 16'h0061, 16'h0000, 16'h0040, 5'b10010);
    step();
    check_state("not_t5", 16'h0009, 16'h0080, 16'h0000, 5'b00000);
    step();

    // div R5,R5,R5: all operands alias, LO then HI writes
    IR = {5'b10000, 4'd5, 4'd5, 4'd5, 15'd0};
    fetch("div");
    check_state("div_t3", 16'h0081, 16'h0000, 16'h0020, 5'b00000);
    step();
    check_state("div_t4", 16'h0061, 16'h0000, 16'h0020, 5'b10000);
    step();
    check_state("div_t5", 16'h000B, 16'h0000, 16'h0000, 5'b00000);
    step();
    check_state("div_t6", 16'h0015, 16'h0000, 16'h0000, 5'b00000);
    step();

    // sub R5,R5,R5 ordinary op with aliased registers
    IR = {5'b00100, 4'd5, 4'd5, 4'd5, 15'd0};
    fetch("alias");
    check_state("alias_t3", 16'h0081, 16'h0000, 16'h0020, 5'b00000);
    step();
    check_state("alias_t4", 16'h0061, 16'h0000, 16'h0020, 5'b00100);
    step();
    check_state("alias_t5", 16'h0009, 16'h0020, 16'h0000, 5'b00000);
    step();

    // undefined opcode acts as a 4-cycle NOP
    IR = 32'hFFFFFFFF;
    fetch("nop");
    check_state("nop_t3", 16'h0001, 16'h0000, 16'h0000, 5'b00000);
    step();

`ifdef SINGLE_STEP_EN
    IR = 32'h18918000;
    check_state("ss_t0", 16'hE061, 16'h0000, 16'h0000, 5'b00011);
    step();
    Step = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_state("ss_hold", 16'h0301, 16'h0000, 16'h0000, 5'b00000);
      step();
    end
    Step = 1'b1;
    step();
    check_state("ss_t3", 16'h0081, 16'h0000, 16'h0004, 5'b00000);
    step();
    step();
    step();
`endif

    // halt parks the FSM with everything low
    IR = {5'b11010, 27'd0};
    fetch("halt");
    check_state("halt_t3", 16'h0001, 16'h0000, 16'h0000, 5'b00000);
    step();
    for (int i = 0; i < 10; i++) begin
      check_state("halt_hold", 16'h0000, 16'h0000, 16'h0000, 5'b00000);
      step();
    end

    // clear leaves halt; then clear abandons an add in T4
    clear = 1'b1;
    #1;
    check_state("halt_clr", 16'h0000, 16'h0000, 16'h0000, 5'b00000);
    clear = 1'b0;
    IR = 32'h18918000;
    step();
    fetch("rst2");
    step();
    check_state("rst2_t4", 16'h0061, 16'h0000, 16'h0008, 5'b00011);
    clear = 1'b1;
    #1;
    check_state("clr_t4", 16'h0000, 16'h0000, 16'h0000, 5'b00000);
    step();
    check_state("clr_hold", 16'h0000, 16'h0000, 16'h0000, 5'b00000);
    clear = 1'b0;
    step();
    check_state("clr_t0", 16'hE061, 16'h0000, 16'h0000, 5'b00011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
